// File: rtl/modulus_hex_loader.sv
// Builds one 64-entry reduction table: entry i = (i * 2^CUR_LOW_POS) mod N,
// streamed out through a registered write port, one entry per cycle.
module modulus_hex_loader #(
  parameter int MODULUS_WIDTH = 1024,
  parameter int CUR_LOW_POS   = 2042
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [MODULUS_WIDTH-1:0] modulus_in,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     wr_en,
  output logic [5:0]               wr_addr,
  output logic [MODULUS_WIDTH-1:0] wr_data
);

  localparam int W     = MODULUS_WIDTH;
  localparam int CNT_W = ($clog2(CUR_LOW_POS + 1) < 1) ? 1 : $clog2(CUR_LOW_POS + 1);

  typedef enum logic [1:0] {S_IDLE, S_DOUBLE, S_WRITE, S_FINISH} state_t;

  // Both operands must already be reduced (< n), so one conditional subtract suffices.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] n);
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    return t[W-1:0];
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   n_q, n_d;
  logic [W-1:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic           wr_en_q, wr_en_d;
  logic [5:0]     wr_addr_q, wr_addr_d;
  logic [W-1:0]   wr_data_q, wr_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // r holds 2^k mod N while doubling and doubles as the table step (base) while writing;
  // the write-data register itself is the running accumulator.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d       = modulus_in;
          busy_d    = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
          if (modulus_in == '0) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            r_d   = (modulus_in == W'(1)) ? '0 : W'(1);
            cnt_d = CNT_W'(CUR_LOW_POS);
            if (CUR_LOW_POS == 0) begin
              state_d = S_WRITE;
              wr_en_d = 1'b1;
            end else begin
              state_d = S_DOUBLE;
            end
          end
        end
      end
      S_DOUBLE: begin
        r_d   = mod_add(r_q, r_q, n_q);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
        end
      end
      S_WRITE: begin
        if (wr_addr_q == 6'd63) begin
          state_d   = S_FINISH;
          wr_en_d   = 1'b0;
          wr_addr_d = '0;
          wr_data_d = '0;
          done_d    = 1'b1;
        end else begin
          wr_addr_d = wr_addr_q + 6'd1;
          wr_data_d = mod_add(wr_data_q, r_q, n_q);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: doc/modulus_hex_loader.md
# modulus_hex_loader

Runtime generator for one 64-entry modular-reduction digit table: for a programmable modulus N it writes entry i = (i · 2^CUR_LOW_POS) mod N, for i = 0..63, into an external table RAM through a simple write port. It lets the squarer's hex reduction tables be reloaded for a new modulus without re-synthesis. One instance feeds one table position.

## Interface
- MODULUS_WIDTH, 1024, width W of the modulus and of each table entry.
- CUR_LOW_POS, 2042, bit position P of the digit's low bit; P ≥ 0.
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request a table build; sampled only in IDLE.
- modulus_in  in  W  modulus N; captured on the accepted start.
- busy  out  1  high from the cycle after start is accepted until the done cycle inclusive; reset 0.
- done  out  1  one-cycle pulse at the end of a build; reset 0.
- error  out  1  one-cycle pulse with done when N = 0; reset 0.
- wr_en  out  1  table write strobe; reset 0.
- wr_addr  out  6  table index; reset 0.
- wr_data  out  W  entry value, always < N; reset 0.

## Operation
- States: IDLE, DOUBLE, WRITE, FINISH.
- IDLE with start=1:
  - Latch N.
  - If N = 0: go to FINISH with the error flag set.
  - Otherwise set r = (N == 1) ? 0 : 1, load the doubling counter with P, and go to DOUBLE (or straight to WRITE if P = 0).
- DOUBLE, one doubling per cycle:
  - t = 2r computed at W+1 bits; r ← (t ≥ N) ? t − N : t.
  - Decrement the counter; after P doublings r = 2^P mod N.
  - On exit, store base = r and set acc = 0, address = 0.
- WRITE, one entry per cycle:
  - Drive wr_en=1, wr_addr=k, wr_data=acc.
  - Update acc ← (acc + base) mod N, with the add at W+1 bits and a single conditional subtract.
  - Run for k = 0..63, then go to FINISH.
- FINISH:
  - Pulse done for one cycle (plus error if flagged), deassert busy the following cycle, and return to IDLE.
  - The error path performs no writes.
- start while not IDLE is ignored; modulus_in changes after capture have no effect.
- Writes are strictly in ascending address order, each address exactly once per build.

## Timing
- Start sampled high in IDLE at edge 0.
- DOUBLE occupies cycles 1..P.
- WRITE occupies cycles P+1..P+64: wr_en high for exactly 64 consecutive cycles, wr_addr = 0..63.
- done/busy timing:
  - Normal build: done pulses at cycle P+65; busy is high cycles 1..P+65.
  - N = 0: done and error pulse at cycle 1.
- A new start is accepted at the earliest in the cycle after done.
- Outputs are registered; wr_en, wr_addr and wr_data change together on the same edge.
- Reset asserted mid-build:
  - All outputs go to 0 immediately; the partial table is left as written and is not valid.
  - The next start restarts from scratch.
- The critical path is one W+1-bit add/compare/subtract per cycle.

## Test plan
- W=8, P=4, N=13, start once:
  - base = 3.
  - Writes in order: addr0=0, addr1=3, addr2=6, addr3=9, addr4=12, addr5=2, …, addr63=7.
  - done at cycle 69; busy high for 69 cycles.
- W=8, P=0, N=13:
  - No DOUBLE cycles; writes i mod 13 (addr13=0, addr63=11).
  - done at cycle 65.
- N=0: done and error pulse at cycle 1; wr_en never asserted; busy high 1 cycle.
- N=1, P=4: all 64 writes carry 0; no error.
- Full-width check, W=1024, P=2042, random odd N:
  - Every entry equals (i · 2^2042) mod N from the golden model.
  - Every entry is < N; no write is dropped or repeated.
- Robustness:
  - Pulse start during DOUBLE and during WRITE: ignored, and the table is unchanged vs. the golden model.
  - Assert reset at WRITE addr 20: all outputs 0 asynchronously.
  - A fresh start then produces a complete correct table.
